// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder slice.
//   WORD_W : data word width
//   OFS_W  : byte-offset bits below the word index
//   CNT_W  : width of the wait-state counter (LATENCY up to 15)
//   state_t: responder FSM states
package mips_mem_pkg;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned OFS_W  = 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage for dmem_responder.
//   clk, rst       : clock, async active-low clear of every word and of rdata
//   we/waddr/wdata : synchronous write port
//   re/raddr/rdata : synchronous read port; rdata holds when re is low
//   dbg_rdata      : combinational read of word DBG_WORD
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DBG_WORD    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata,
    output logic [WORD_W-1:0] dbg_rdata
);
    localparam logic [ADDR_W-1:0] DBG_IDX = ADDR_W'(DBG_WORD);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem   <= '{default: '0};
            rdata <= '0;
        end else begin
            if (we) mem[waddr] <= wdata;
            if (re) rdata <= mem[raddr];
        end
    end

    assign dbg_rdata = mem[DBG_IDX];
endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the memory stage of the MIPS pipeline.
// Accepts one word access in IDLE, holds the pipeline for LATENCY wait cycles,
// performs the access on the edge leaving WAIT, then pulses resp_valid once.
// Misaligned or out-of-range accesses skip WAIT and respond with resp_err.
//   clk, rst (async, active-low)
//   req_valid/req_we/req_addr/req_wdata : access request from the memory stage
//   req_ready  : responder idle and able to accept
//   stall      : hold memory stage and earlier stages
//   resp_valid/resp_err/resp_rdata : one-cycle response, registered load data
//   testValue  : live contents of the word at byte address TEST_ADDR
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned TEST_ADDR   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [31:0]       testValue
);
    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt;
    logic                cap_we;
    logic                cap_err;
    logic [ADDR_W-1:0]   cap_idx;
    logic [WORD_W-1:0]   cap_wdata;
    logic                req_bad;
    logic                access;
    logic                mem_we;
    logic                mem_re;

    assign req_bad = (req_addr[OFS_W-1:0] != '0) ||
                     ({2'b00, req_addr[31:OFS_W]} >= DEPTH_WORDS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    // req_valid is qualified by rst so stall stays low while reset is held.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        stall      = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && rst) begin
                    stall    = 1'b1;
                    state_nx = req_bad ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (cnt == '0) state_nx = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = cap_err;
                state_nx   = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_err   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_err   <= req_bad;
                        cap_idx   <= req_addr[ADDR_W+OFS_W-1:OFS_W];
                        cap_wdata <= req_wdata;
                        cnt       <= CNT_W'(LATENCY - 1);
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // The access fires on the edge that leaves WAIT; erroring requests never reach WAIT.
    assign access = (state == ST_WAIT) && (cnt == '0);
    assign mem_we = access && cap_we;
    assign mem_re = access && !cap_we;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W),
        .DBG_WORD    (TEST_ADDR >> OFS_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .we        (mem_we),
        .waddr     (cap_idx),
        .wdata     (cap_wdata),
        .re        (mem_re),
        .raddr     (cap_idx),
        .rdata     (resp_rdata),
        .dbg_rdata (testValue)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2, TEST_ADDR=0).
module tb_dmem_responder;
    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] testValue;

    int unsigned tests = 0;
    int unsigned fails = 0;

    dmem_responder #(
        .DEPTH_WORDS (64),
        .LATENCY     (LAT),
        .TEST_ADDR   (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .testValue  (testValue)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle, #1 after the edge. Returns in the RESP cycle if
    // keep_valid is set, otherwise in the IDLE cycle after RESP.
    task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wd, input logic exp_err,
                             input logic [31:0] exp_rd, input logic scramble,
                             input logic keep_valid);
        int unsigned n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        #1;
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        chk({tag, "_stall0"}, {31'b0, stall}, 32'd1);
        n = 0;
        do begin
            step();
            n++;
            if (!resp_valid) begin
                chk({tag, "_stallw"}, {31'b0, stall}, 32'd1);
                if (scramble) begin
                    req_addr  = 32'h0000_0030;
                    req_wdata = ~wd;
                end
            end
        end while (!resp_valid && n < 20);
        chk({tag, "_lat"}, n, exp_err ? 32'd1 : LAT + 1);
        chk({tag, "_rvalid"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, "_rerr"}, {31'b0, resp_err}, {31'b0, exp_err});
        chk({tag, "_rdata"}, resp_rdata, exp_rd);
        chk({tag, "_stallr"}, {31'b0, stall}, 32'd0);
        chk({tag, "_readyr"}, {31'b0, req_ready}, 32'd0);
        if (!keep_valid) begin
            req_valid = 1'b0;
            step();
            chk({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
            chk({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        int unsigned pulses;
        rst       = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        #2;
        chk("rst_stall_gated", {31'b0, stall}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        step();
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("post_rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("post_rst_err", {31'b0, resp_err}, 32'd0);
        chk("post_rst_rdata", resp_rdata, 32'h0);
        chk("post_rst_tv", testValue, 32'h0);
        chk("post_rst_stall", {31'b0, stall}, 32'd0);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

        do_access("ld00",   1'b0, 32'h00, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0);
        do_access("stDB",   1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0);
        do_access("ld10",   1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        do_access("ld12",   1'b0, 32'h12, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        do_access("st100",  1'b1, 32'h100, 32'h1111_2222, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        do_access("ld00b",  1'b0, 32'h00, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0);
        do_access("stFC",   1'b1, 32'hFC, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0, 1'b0);
        do_access("ldFC",   1'b0, 32'hFC, 32'h0,        1'b0, 32'hA5A5A5A5, 1'b0, 1'b0);

        chk("tv_before", testValue, 32'h0);
        do_access("st55",   1'b1, 32'h00, 32'h55,       1'b0, 32'hA5A5A5A5, 1'b0, 1'b1);
        chk("tv_resp", testValue, 32'h55);
        req_valid = 1'b0;
        step();
        chk("tv_after", testValue, 32'h55);

        do_access("stHold", 1'b1, 32'h40, 32'hCAFEF00D, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0);
        do_access("ld30",   1'b0, 32'h30, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0);
        do_access("ld40k",  1'b0, 32'h40, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 1'b1);
        step();
        chk("resp_no_accept_ready", {31'b0, req_ready}, 32'd1);
        chk("resp_no_accept_valid", {31'b0, resp_valid}, 32'd0);
        do_access("ld40",   1'b0, 32'h40, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 1'b0);

        // Abort a store while in WAIT.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        step();
        chk("abort_in_wait", {31'b0, stall}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_stall", {31'b0, stall}, 32'd0);
        chk("abort_tv", testValue, 32'h0);
        step();
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (resp_valid) pulses++;
        end
        chk("abort_no_pulse", pulses, 32'd0);
        do_access("ld20",   1'b0, 32'h20, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
